keypad_number_entry: RTL

Parametrised multi-digit numeric entry block for the Bingo keyboard front end. It sits between the PS/2 keyboard decoder (key_valid / last_change / key_down) and the game FSM. It accumulates up to DIGITS decimal digits with backspace and clear, and on Enter commits a range-checked binary value as a one-cycle pulse. One-key-at-a-time lockout: a new make code is accepted only after the previously accepted key has been released.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/keypad_number_entry_bcd_to_bin.sv | 17 +
 rtl/keypad_number_entry.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: scan-code constants, key-class and FSM state types for keypad_number_entry.
package keypad_pkg;
  localparam logic [8:0] SC_0        = 9'h045;
  localparam logic [8:0] SC_1        = 9'h016;
  localparam logic [8:0] SC_2        = 9'h01E;
  localparam logic [8:0] SC_3        = 9'h026;
  localparam logic [8:0] SC_4        = 9'h025;
  localparam logic [8:0] SC_5        = 9'h02E;
  localparam logic [8:0] SC_6        = 9'h036;
  localparam logic [8:0] SC_7        = 9'h03D;
  localparam logic [8:0] SC_8        = 9'h03E;
  localparam logic [8:0] SC_9        = 9'h046;
  localparam logic [8:0] SC_KP_0     = 9'h070;
  localparam logic [8:0] SC_KP_1     = 9'h069;
  localparam logic [8:0] SC_KP_2     = 9'h072;
  localparam logic [8:0] SC_KP_3     = 9'h07A;
  localparam logic [8:0] SC_KP_4     = 9'h06B;
  localparam logic [8:0] SC_KP_5     = 9'h073;
  localparam logic [8:0] SC_KP_6     = 9'h074;
  localparam logic [8:0] SC_KP_7     = 9'h06C;
  localparam logic [8:0] SC_KP_8     = 9'h075;
  localparam logic [8:0] SC_KP_9     = 9'h07D;
  localparam logic [8:0] SC_ENTER    = 9'h05A;
  localparam logic [8:0] SC_KP_ENTER = 9'h15A;
  localparam logic [8:0] SC_BKSP     = 9'h066;
  localparam logic [8:0] SC_ESC      = 9'h076;
  typedef enum logic [2:0] {KC_DIGIT, KC_ENTER, KC_BKSP, KC_ESC, KC_OTHER} key_class_t;
  typedef enum logic {S_IDLE, S_HELD} state_t;
endpackage

// File: rtl/keypad_number_entry_bcd_to_bin.sv
// bcd_to_bin: combinational packed-BCD to binary converter, most significant digit first.
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int VAL_W  = $clog2(10**DIGITS)
) (
  input  logic [4*DIGITS-1:0] i_bcd,
  output logic [VAL_W-1:0]    o_bin
);
  localparam int AW = VAL_W + 4;
  logic [AW-1:0] w_acc;
  always_comb begin
    w_acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--)
      w_acc = w_acc * AW'(10) + {{VAL_W{1'b0}}, i_bcd[4*i +: 4]};
    o_bin = VAL_W'(w_acc);
  end
endmodule

// File: rtl/keypad_number_entry.sv
// keypad_number_entry: multi-digit decimal entry with one-key lockout and range-checked commit.
// Define KEYPAD_NUMPAD_EN to also accept numpad digits and keypad Enter.
module keypad_number_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int MIN_VALUE = 1,
  parameter int MAX_VALUE = 25,
  parameter int VAL_W     = $clog2(10**DIGITS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [8:0]                   last_change,
  input  logic [511:0]                 key_down,
  input  logic                         clear,
  output logic [4*DIGITS-1:0]          bcd_digits,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         busy,
  output logic                         commit_pulse,
  output logic [VAL_W-1:0]             commit_value,
  output logic                         reject_pulse
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [VAL_W-1:0] MIN_V = VAL_W'(MIN_VALUE);
  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VALUE);
  state_t           r_state, w_state;
  logic [8:0]       r_held, w_held;
  logic [BW-1:0]    r_buf, w_buf;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [VAL_W-1:0] r_val, w_val, w_bin;
  logic             r_commit, w_commit, r_reject, w_reject;
  key_class_t       w_class;
  logic [3:0]       w_digit;
  logic             w_make, w_break;
  assign w_make  = key_valid && key_down[last_change];
  assign w_break = key_valid && !key_down[last_change];
  bcd_to_bin #(.DIGITS(DIGITS), .VAL_W(VAL_W)) u_bcd_to_bin (
    .i_bcd (r_buf),
    .o_bin (w_bin)
  );
  always_comb begin
    w_class = KC_DIGIT;
    w_digit = 4'd0;
    case (last_change)
      SC_0:        w_digit = 4'd0;
      SC_1:        w_digit = 4'd1;
      SC_2:        w_digit = 4'd2;
      SC_3:        w_digit = 4'd3;
      SC_4:        w_digit = 4'd4;
      SC_5:        w_digit = 4'd5;
      SC_6:        w_digit = 4'd6;
      SC_7:        w_digit = 4'd7;
      SC_8:        w_digit = 4'd8;
      SC_9:        w_digit = 4'd9;
`ifdef KEYPAD_NUMPAD_EN
      SC_KP_0:     w_digit = 4'd0;
      SC_KP_1:     w_digit = 4'd1;
      SC_KP_2:     w_digit = 4'd2;
      SC_KP_3:     w_digit = 4'd3;
      SC_KP_4:     w_digit = 4'd4;
      SC_KP_5:     w_digit = 4'd5;
      SC_KP_6:     w_digit = 4'd6;
      SC_KP_7:     w_digit = 4'd7;
      SC_KP_8:     w_digit = 4'd8;
      SC_KP_9:     w_digit = 4'd9;
      SC_KP_ENTER: w_class = KC_ENTER;
`endif
      SC_ENTER:    w_class = KC_ENTER;
      SC_BKSP:     w_class = KC_BKSP;
      SC_ESC:      w_class = KC_ESC;
      default:     w_class = KC_OTHER;
    endcase
  end
  // clear still lets the lockout be taken, it only suppresses the buffer action
  always_comb begin
    w_state  = r_state;
    w_held   = r_held;
    w_buf    = r_buf;
    w_cnt    = r_cnt;
    w_val    = r_val;
    w_commit = 1'b0;
    w_reject = 1'b0;
    if (r_state == S_IDLE && w_make && w_class != KC_OTHER) begin
      w_state = S_HELD;
      w_held  = last_change;
      if (!clear)
        case (w_class)
          KC_DIGIT:
            if (r_cnt < CW'(DIGITS)) begin
              w_buf = (r_buf << 4) | BW'(w_digit);
              w_cnt = r_cnt + CW'(1);
            end else
              w_reject = 1'b1;
          KC_BKSP:
            if (r_cnt != '0) begin
              w_buf = r_buf >> 4;
              w_cnt = r_cnt - CW'(1);
            end
          KC_ESC: begin
            w_buf = '0;
            w_cnt = '0;
          end
          KC_ENTER:
            if (r_cnt != '0 && w_bin >= MIN_V && w_bin <= MAX_V) begin
              w_val    = w_bin;
              w_commit = 1'b1;
              w_buf    = '0;
              w_cnt    = '0;
            end else
              w_reject = 1'b1;
          default: ;
        endcase
    end else if (r_state == S_HELD && w_break && last_change == r_held)
      w_state = S_IDLE;
    if (clear) begin
      w_buf = '0;
      w_cnt = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= S_IDLE;
      r_held   <= '0;
      r_buf    <= '0;
      r_cnt    <= '0;
      r_val    <= '0;
      r_commit <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_held   <= w_held;
      r_buf    <= w_buf;
      r_cnt    <= w_cnt;
      r_val    <= w_val;
      r_commit <= w_commit;
      r_reject <= w_reject;
    end
  assign bcd_digits   = r_buf;
  assign digit_count  = r_cnt;
  assign busy         = (r_state == S_HELD);
  assign commit_pulse = r_commit;
  assign commit_value = r_val;
  assign reject_pulse = r_reject;
endmodule
